// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo
//   Memory-mapped UART for the RV32I SoC data port. It has TX and RX FIFOs
//   with power-of-two depth, a runtime baud divisor, sticky error flags,
//   internal loopback and a maskable level interrupt.
//
//   Register map (word offset, iADDR[3:2]):
//     0x0 DATA   write: push TX byte     read: pop RX byte (0 when empty)
//     0x4 STATUS [0]RXNE [1]TXFULL [2]TXIDLE [3]RXOVR [4]FERR [5]TXOVF
//                bits [5:3] are sticky and write-1-to-clear
//     0x8 CTRL   [0]RXIE [1]TXIE [2]LOOP
//     0xC DIVR   [15:0] clocks per bit; a write below 4 is stored as 4
//
//   Ports:
//     iCLK, iRST   clock (rising edge) and asynchronous active-low reset
//     iCE/iRD/iWR  access strobes; write wins when both strobes are high
//     iADDR        byte address; bits [1:0] are ignored
//     iDATA/oDATA  write data and registered read data
//     oIRQ         registered level interrupt
//     iRXD/oTXD    serial input (asynchronous) and output (idle high)
module uart_mmio_fifo #(
    parameter int CLK_HZ   = 50000000,
    parameter int BAUD     = 115200,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCE,
    input  logic        iRD,
    input  logic        iWR,
    input  logic [3:0]  iADDR,
    input  logic [31:0] iDATA,
    output logic [31:0] oDATA,
    output logic        oIRQ,
    input  logic        iRXD,
    output logic        oTXD
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [15:0]    DIV0    = 16'(CLK_HZ / BAUD);
    localparam logic [15:0]    DIV_MIN = 16'd4;
    localparam logic [TAW:0]   TX_FULL = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0]   RX_FULL = (RAW+1)'(RX_DEPTH);
    localparam logic [TAW-1:0] TX_PONE = (TAW)'(1);
    localparam logic [TAW:0]   TX_CONE = (TAW+1)'(1);
    localparam logic [RAW-1:0] RX_PONE = (RAW)'(1);
    localparam logic [RAW:0]   RX_CONE = (RAW+1)'(1);

    typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_CTRL, REG_DIVR} reg_sel_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // Control / status registers
    logic [2:0]  r_ctrl;
    logic [15:0] r_divr;
    logic        r_rxovr, r_ferr, r_txovf;
    logic [31:0] r_odata;
    logic        r_irq;

    // TX FIFO and shifter
    logic [7:0]     r_tx_mem [TX_DEPTH];
    logic [TAW-1:0] r_tx_wp, r_tx_rp;
    logic [TAW:0]   r_tx_cnt;
    uart_state_t    r_tx_state;
    logic [7:0]     r_tx_shift;
    logic [2:0]     r_tx_bit;
    logic [15:0]    r_tx_clk, r_tx_div;
    logic           r_tx_line;

    // RX FIFO, synchroniser and shifter
    logic [7:0]     r_rx_mem [RX_DEPTH];
    logic [RAW-1:0] r_rx_wp, r_rx_rp;
    logic [RAW:0]   r_rx_cnt;
    logic           r_rx_s1, r_rx_s2, r_rx_prev;
    uart_state_t    r_rx_state;
    logic [7:0]     r_rx_shift;
    logic [2:0]     r_rx_bit;
    logic [15:0]    r_rx_clk, r_rx_div;

    reg_sel_t w_sel;
    logic     w_wr, w_rd, w_st_wr;
    logic     w_tx_wr, w_tx_push, w_tx_pop, w_tx_empty, w_tx_full, w_tx_bit_end, w_txidle;
    logic     w_tx_ovf_evt;
    logic     w_rx_src, w_rx_in, w_rx_pop, w_rx_push, w_rx_empty, w_rx_full;
    logic     w_rx_half, w_rx_bit_end, w_rx_tick, w_rx_done, w_rx_push_req;
    logic     w_rx_ferr_evt, w_rx_ovr_evt;
    logic [5:0] w_status;
    logic     w_unused;

    // ---------------- Bus decode ----------------
    assign w_sel   = reg_sel_t'(iADDR[3:2]);
    assign w_wr    = iCE & iWR;
    assign w_rd    = iCE & iRD & ~iWR;
    assign w_st_wr = w_wr & (w_sel == REG_STATUS);
    assign w_tx_wr = w_wr & (w_sel == REG_DATA);
    assign w_rx_pop = w_rd & (w_sel == REG_DATA) & ~w_rx_empty;
    assign w_unused = &{1'b0, iADDR[1:0], iDATA[31:16]};

    // ---------------- TX FIFO ----------------
    assign w_tx_empty   = (r_tx_cnt == '0);
    assign w_tx_full    = (r_tx_cnt == TX_FULL);
    // A write into a full FIFO still lands if the shifter pops in the same cycle.
    assign w_tx_push    = w_tx_wr & (~w_tx_full | w_tx_pop);
    assign w_tx_ovf_evt = w_tx_wr & ~w_tx_push;

    // NOTE: FIFO storage has no reset; the count alone decides what is valid,
    // which keeps the array as plain RAM.
    always_ff @(posedge iCLK) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= iDATA[7:0];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            if (w_tx_push) r_tx_wp <= r_tx_wp + TX_PONE;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_PONE;
            if (w_tx_push & ~w_tx_pop)      r_tx_cnt <= r_tx_cnt + TX_CONE;
            else if (~w_tx_push & w_tx_pop) r_tx_cnt <= r_tx_cnt - TX_CONE;
        end
    end

    // ---------------- TX FSM ----------------
    assign w_tx_bit_end = (r_tx_clk == r_tx_div - 16'd1);
    // Pop from IDLE, or at the end of a stop bit for a back-to-back frame.
    assign w_tx_pop = ~w_tx_empty &
                      ((r_tx_state == S_IDLE) | ((r_tx_state == S_STOP) & w_tx_bit_end));
    assign w_txidle = w_tx_empty & (r_tx_state == S_IDLE);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_tx_state <= S_IDLE;
            r_tx_line  <= 1'b1;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_tx_clk   <= '0;
            r_tx_div   <= DIV0;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_shift <= r_tx_mem[r_tx_rp];
                        r_tx_line  <= 1'b0;
                        r_tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit   <= '0;
                        r_tx_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tx_bit_end) begin
                        if (r_tx_bit == 3'd7) begin
                            r_tx_line  <= 1'b1;
                            r_tx_state <= S_STOP;
                        end else begin
                            r_tx_line  <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= r_tx_bit + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tx_bit_end) begin
                        if (w_tx_pop) begin
                            r_tx_shift <= r_tx_mem[r_tx_rp];
                            r_tx_line  <= 1'b0;
                            r_tx_state <= S_START;
                        end else begin
                            r_tx_line  <= 1'b1;
                            r_tx_state <= S_IDLE;
                        end
                    end
                end
            endcase
            // Bit timer restarts on every bit boundary and picks up the current
            // divisor there, so a DIVR write never stretches a bit in flight.
            if ((r_tx_state == S_IDLE) || w_tx_bit_end) begin
                r_tx_clk <= '0;
                r_tx_div <= r_divr;
            end else begin
                r_tx_clk <= r_tx_clk + 16'd1;
            end
        end
    end

    // ---------------- RX synchroniser ----------------
    assign w_rx_src = r_ctrl[2] ? r_tx_line : iRXD;
    assign w_rx_in  = r_rx_s2;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= w_rx_src;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // ---------------- RX FSM ----------------
    assign w_rx_half     = (r_rx_clk == (r_rx_div >> 1) - 16'd1);
    assign w_rx_bit_end  = (r_rx_clk == r_rx_div - 16'd1);
    assign w_rx_tick     = ((r_rx_state == S_START) & w_rx_half) |
                           (((r_rx_state == S_DATA) | (r_rx_state == S_STOP)) & w_rx_bit_end);
    assign w_rx_done     = (r_rx_state == S_STOP) & w_rx_bit_end;
    assign w_rx_push_req = w_rx_done & w_rx_in;
    assign w_rx_ferr_evt = w_rx_done & ~w_rx_in;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_rx_state <= S_IDLE;
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
            r_rx_clk   <= '0;
            r_rx_div   <= DIV0;
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    if (r_rx_prev & ~w_rx_in) r_rx_state <= S_START;
                end
                S_START: begin
                    // Mid-start re-check rejects glitches shorter than half a bit.
                    if (w_rx_half) r_rx_state <= w_rx_in ? S_IDLE : S_DATA;
                    r_rx_bit <= '0;
                end
                S_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_shift <= {w_rx_in, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_rx_bit_end) r_rx_state <= S_IDLE;
                end
            endcase
            // Divisor is captured while idle, i.e. at the start edge of a frame.
            if ((r_rx_state == S_IDLE) || w_rx_tick) r_rx_clk <= '0;
            else                                      r_rx_clk <= r_rx_clk + 16'd1;
            if (r_rx_state == S_IDLE) r_rx_div <= r_divr;
        end
    end

    // ---------------- RX FIFO ----------------
    assign w_rx_empty   = (r_rx_cnt == '0);
    assign w_rx_full    = (r_rx_cnt == RX_FULL);
    assign w_rx_push    = w_rx_push_req & (~w_rx_full | w_rx_pop);
    assign w_rx_ovr_evt = w_rx_push_req & ~w_rx_push;

    always_ff @(posedge iCLK) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + RX_PONE;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_PONE;
            if (w_rx_push & ~w_rx_pop)      r_rx_cnt <= r_rx_cnt + RX_CONE;
            else if (~w_rx_push & w_rx_pop) r_rx_cnt <= r_rx_cnt - RX_CONE;
        end
    end

    // ---------------- Registers, read port, IRQ ----------------
    assign w_status = {r_txovf, r_ferr, r_rxovr, w_txidle, w_tx_full, ~w_rx_empty};

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_ctrl  <= '0;
            r_divr  <= DIV0;
            r_rxovr <= 1'b0;
            r_ferr  <= 1'b0;
            r_txovf <= 1'b0;
            r_odata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_txidle);
            if (w_wr && (w_sel == REG_CTRL)) r_ctrl <= iDATA[2:0];
            if (w_wr && (w_sel == REG_DIVR))
                r_divr <= (iDATA[15:0] < DIV_MIN) ? DIV_MIN : iDATA[15:0];
            // A new event in the same cycle as a clear keeps the flag set.
            r_rxovr <= (r_rxovr & ~(w_st_wr & iDATA[3])) | w_rx_ovr_evt;
            r_ferr  <= (r_ferr  & ~(w_st_wr & iDATA[4])) | w_rx_ferr_evt;
            r_txovf <= (r_txovf & ~(w_st_wr & iDATA[5])) | w_tx_ovf_evt;
            if (w_rd) begin
                case (w_sel)
                    REG_DATA:   r_odata <= w_rx_empty ? 32'd0 : {24'd0, r_rx_mem[r_rx_rp]};
                    REG_STATUS: r_odata <= {26'd0, w_status};
                    REG_CTRL:   r_odata <= {29'd0, r_ctrl};
                    REG_DIVR:   r_odata <= {16'd0, r_divr};
                endcase
            end
        end
    end

    assign oDATA = r_odata;
    assign oIRQ  = r_irq;
    assign oTXD  = r_ctrl[2] | r_tx_line;

endmodule
